// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous level: 2-flop synchroniser, then a qualifying FSM
// that accepts a level change only after STABLE_CYCLES consecutive differing samples.
`timescale 1ns/1ps

module input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic       dout,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    localparam int unsigned GLITCH_W = 8;
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'b00,
        LOW_QUAL    = 2'b01,
        HIGH_STABLE = 2'b10,
        HIGH_QUAL   = 2'b11
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 sync1;
    logic                 sync2;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 dout_d;
    logic                 rise_d;
    logic                 fall_d;
    logic [GLITCH_W-1:0]  glitch_d;
    logic [GLITCH_W-1:0]  glitch_inc;

    // State and output registers; everything clears asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            state_q    <= LOW_STABLE;
            cnt_q      <= '0;
            dout       <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            sync1      <= din;
            sync2      <= sync1;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout       <= dout_d;
            rise       <= rise_d;
            fall       <= fall_d;
            glitch_cnt <= glitch_d;
        end
    end

    assign glitch_inc = (glitch_cnt != GLITCH_MAX) ? glitch_cnt + GLITCH_W'(1) : glitch_cnt;

    // Next-state logic; the LOW_*/HIGH_* half of the state always matches dout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = glitch_cnt;
        case (state_q)
            LOW_STABLE, LOW_QUAL: begin
                if (sync2) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = HIGH_STABLE;
                        cnt_d   = '0;
                        dout_d  = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = LOW_QUAL;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = LOW_STABLE;
                    if (cnt_q != '0) begin
                        cnt_d    = '0;
                        glitch_d = glitch_inc;
                    end
                end
            end
            HIGH_STABLE, HIGH_QUAL: begin
                if (!sync2) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = LOW_STABLE;
                        cnt_d   = '0;
                        dout_d  = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = HIGH_QUAL;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = HIGH_STABLE;
                    if (cnt_q != '0) begin
                        cnt_d    = '0;
                        glitch_d = glitch_inc;
                    end
                end
            end
            default: begin
                state_d = LOW_STABLE;
            end
        endcase
    end

    assign busy = (cnt_q != '0);

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: per-cycle vector table plus hand-written
// sequences for reset, async abort, glitch saturation and STABLE_CYCLES=1.
`timescale 1ns/1ps

module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       din1;
    logic       dout, rise, fall, busy;
    logic [7:0] glitch_cnt;
    logic       dout1, rise1, fall1, busy1;
    logic [7:0] glitch_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    input_debouncer u_dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .dout       (dout),
        .rise       (rise),
        .fall       (fall),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    input_debouncer #(.STABLE_CYCLES(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .din        (din1),
        .dout       (dout1),
        .rise       (rise1),
        .fall       (fall1),
        .busy       (busy1),
        .glitch_cnt (glitch_cnt1)
    );

    // One row per clock edge: din applied before the edge, outputs expected after it.
    typedef struct {
        logic       din;
        logic [3:0] orfb;   // {dout, rise, fall, busy}
        logic [7:0] glitch;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic d, logic [3:0] orfb, logic [7:0] g);
        vec_t v;
        v.din    = d;
        v.orfb   = orfb;
        v.glitch = g;
        vecs.push_back(v);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(string name, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_byte(string name, logic [7:0] act, logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, logic o, logic r, logic f, logic b, logic [7:0] g);
        check_bit({tag, " dout"}, dout, o);
        check_bit({tag, " rise"}, rise, r);
        check_bit({tag, " fall"}, fall, f);
        check_bit({tag, " busy"}, busy, b);
        check_byte({tag, " glitch"}, glitch_cnt, g);
    endtask

    // After reset release with din=1: first edge is E0, dout/rise at E5.
    task automatic release_check(string tag, logic [7:0] g);
        for (int k = 0; k < 7; k++) begin
            tick;
            check_outs($sformatf("%s e%0d", tag, k), k >= 5, k == 5, 1'b0,
                       (k >= 2) && (k <= 4), g);
        end
    endtask

    task automatic pulses(int n);
        repeat (n) begin
            din = 1'b1;
            tick;
            din = 1'b0;
            tick;
        end
        repeat (3) tick;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Clean fall from dout=1
        add(1'b0, 4'b1000, 8'd0); add(1'b0, 4'b1000, 8'd0);
        add(1'b0, 4'b1001, 8'd0); add(1'b0, 4'b1001, 8'd0); add(1'b0, 4'b1001, 8'd0);
        add(1'b0, 4'b0010, 8'd0);
        add(1'b0, 4'b0000, 8'd0); add(1'b0, 4'b0000, 8'd0);
        add(1'b0, 4'b0000, 8'd0); add(1'b0, 4'b0000, 8'd0);
        // Clean rise
        add(1'b1, 4'b0000, 8'd0); add(1'b1, 4'b0000, 8'd0);
        add(1'b1, 4'b0001, 8'd0); add(1'b1, 4'b0001, 8'd0); add(1'b1, 4'b0001, 8'd0);
        add(1'b1, 4'b1100, 8'd0);
        add(1'b1, 4'b1000, 8'd0); add(1'b1, 4'b1000, 8'd0);
        add(1'b1, 4'b1000, 8'd0); add(1'b1, 4'b1000, 8'd0);
        // Clean fall again
        add(1'b0, 4'b1000, 8'd0); add(1'b0, 4'b1000, 8'd0);
        add(1'b0, 4'b1001, 8'd0); add(1'b0, 4'b1001, 8'd0); add(1'b0, 4'b1001, 8'd0);
        add(1'b0, 4'b0010, 8'd0);
        add(1'b0, 4'b0000, 8'd0); add(1'b0, 4'b0000, 8'd0);
        add(1'b0, 4'b0000, 8'd0); add(1'b0, 4'b0000, 8'd0);
        // 3-cycle high pulse: rejected, one glitch
        add(1'b1, 4'b0000, 8'd0); add(1'b1, 4'b0000, 8'd0); add(1'b1, 4'b0001, 8'd0);
        add(1'b0, 4'b0001, 8'd0); add(1'b0, 4'b0001, 8'd0);
        add(1'b0, 4'b0000, 8'd1); add(1'b0, 4'b0000, 8'd1); add(1'b0, 4'b0000, 8'd1);
        // 4-cycle high pulse: dout high for exactly 4 cycles
        add(1'b1, 4'b0000, 8'd1); add(1'b1, 4'b0000, 8'd1);
        add(1'b1, 4'b0001, 8'd1); add(1'b1, 4'b0001, 8'd1);
        add(1'b0, 4'b0001, 8'd1); add(1'b0, 4'b1100, 8'd1);
        add(1'b0, 4'b1001, 8'd1); add(1'b0, 4'b1001, 8'd1); add(1'b0, 4'b1001, 8'd1);
        add(1'b0, 4'b0010, 8'd1); add(1'b0, 4'b0000, 8'd1); add(1'b0, 4'b0000, 8'd1);
        // Bounce 1,0,1,0 then hold 1: two collapses, then accepted
        add(1'b1, 4'b0000, 8'd1); add(1'b0, 4'b0000, 8'd1);
        add(1'b1, 4'b0001, 8'd1); add(1'b0, 4'b0000, 8'd2);
        add(1'b1, 4'b0001, 8'd2); add(1'b1, 4'b0000, 8'd3);
        add(1'b1, 4'b0001, 8'd3); add(1'b1, 4'b0001, 8'd3); add(1'b1, 4'b0001, 8'd3);
        add(1'b1, 4'b1100, 8'd3); add(1'b1, 4'b1000, 8'd3);

        // Reset held 45 ns with din=1
        reset = 1'b1;
        din   = 1'b1;
        din1  = 1'b0;
        #1 reset = 1'b0;
        #5;
        for (int i = 0; i < 4; i++) begin
            check_outs($sformatf("rst t%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
            #10;
        end
        reset = 1'b1;
        release_check("rel", 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            din = vecs[i].din;
            tick;
            check_outs($sformatf("vec%0d", i), vecs[i].orfb[3], vecs[i].orfb[2],
                       vecs[i].orfb[1], vecs[i].orfb[0], vecs[i].glitch);
        end

        // Async reset while a 0->1 candidate has cnt=2
        din = 1'b0;
        repeat (8) tick;
        check_bit("pre dout", dout, 1'b0);
        din = 1'b1;
        repeat (4) tick;
        check_bit("mid busy", busy, 1'b1);
        check_byte("mid glitch", glitch_cnt, 8'd3);
        #4 reset = 1'b0;
        #1 check_outs("async", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        #8 reset = 1'b1;
        release_check("rerel", 8'd0);

        // Glitch counter saturation with 1-cycle pulses
        din = 1'b0;
        repeat (8) tick;
        check_bit("sat pre dout", dout, 1'b0);
        pulses(100);
        check_byte("sat100", glitch_cnt, 8'd100);
        pulses(155);
        check_byte("sat255", glitch_cnt, 8'd255);
        pulses(45);
        check_byte("sat300", glitch_cnt, 8'd255);
        check_bit("sat dout", dout, 1'b0);

        // STABLE_CYCLES=1: a 1-cycle pulse passes through, 2 edges late
        din1 = 1'b1;
        tick;
        din1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick;
            check_bit($sformatf("sc1 e%0d dout", k), dout1, k == 2);
            check_bit($sformatf("sc1 e%0d rise", k), rise1, k == 2);
            check_bit($sformatf("sc1 e%0d fall", k), fall1, k == 3);
            check_bit($sformatf("sc1 e%0d busy", k), busy1, 1'b0);
        end
        check_byte("sc1 glitch", glitch_cnt1, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
